// File: rtl/imm_gen_pipe.sv
// Registered immediate generator at the decode->execute boundary.
// Decodes I/S/B/U/J/Z immediates plus pc-relative target into a 2-entry skid buffer.
module imm_gen_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [2:0]      in_imm_sel,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_target,
    output logic [2:0]      out_sel,
    output logic            out_illegal
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t state_q, state_d;
    logic   alive_q;
    logic   accept, drain;
    logic   load_main, load_skid, shift_skid;

    function automatic logic signed [XLEN-1:0] decode_imm(input logic [31:0] instr,
                                                          input logic [2:0]  sel);
        logic signed [31:0] v;
        case (sel)
            3'b000:  v = {{20{instr[31]}}, instr[31:20]};
            3'b001:  v = {instr[31:12], 12'b0};
            3'b010:  v = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            3'b011:  v = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            3'b100:  v = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            3'b101:  v = {27'b0, instr[19:15]};
            default: v = '0;
        endcase
        return XLEN'(v);
    endfunction

    // Stage p0: combinational decode of the offered entry
    logic signed [XLEN-1:0] imm_p0;
    logic        [XLEN-1:0] tgt_p0;
    logic                   illegal_p0;
    logic                   unused_opcode;

    assign imm_p0        = decode_imm(in_instr, in_imm_sel);
    assign tgt_p0        = in_pc + $unsigned(imm_p0);
    assign illegal_p0    = in_imm_sel[2] & in_imm_sel[1];
    assign unused_opcode = ^in_instr[6:0];

    // alive_q keeps in_ready low through reset and for the first cycle after it
    assign in_ready  = alive_q && (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    always_comb begin
        state_d    = state_q;
        load_main  = 1'b0;
        load_skid  = 1'b0;
        shift_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d   = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                if (accept && !drain) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (drain && !accept) begin
                    state_d = EMPTY;
                end else if (accept && drain) begin
                    load_main = 1'b1;
                end
            end
            FULL: begin
                if (drain) begin
                    state_d    = ONE;
                    shift_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d    = EMPTY;
            load_main  = 1'b0;
            load_skid  = 1'b0;
            shift_skid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            alive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            alive_q <= 1'b1;
        end
    end

    // Stage p1: main register drives the outputs, skid holds the overflow entry
    logic signed [XLEN-1:0] imm_p1,  skid_imm_p1;
    logic        [XLEN-1:0] tgt_p1,  skid_tgt_p1;
    logic        [2:0]      sel_p1,  skid_sel_p1;
    logic                   ill_p1,  skid_ill_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            imm_p1 <= '0;
            tgt_p1 <= '0;
            sel_p1 <= '0;
            ill_p1 <= 1'b0;
        end else if (load_main) begin
            imm_p1 <= imm_p0;
            tgt_p1 <= tgt_p0;
            sel_p1 <= in_imm_sel;
            ill_p1 <= illegal_p0;
        end else if (shift_skid) begin
            imm_p1 <= skid_imm_p1;
            tgt_p1 <= skid_tgt_p1;
            sel_p1 <= skid_sel_p1;
            ill_p1 <= skid_ill_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_imm_p1 <= imm_p0;
            skid_tgt_p1 <= tgt_p0;
            skid_sel_p1 <= in_imm_sel;
            skid_ill_p1 <= illegal_p0;
        end
    end

    assign out_imm     = $unsigned(imm_p1);
    assign out_target  = tgt_p1;
    assign out_sel     = sel_p1;
    assign out_illegal = ill_p1;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: 32-bit and 64-bit instances share the stimulus.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [2:0]  in_imm_sel;
    logic [31:0] pc32;
    logic [63:0] pc64;

    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_imm32, out_target32;
    logic [2:0]  out_sel32;
    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64, out_target64;
    logic [2:0]  out_sel64;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32)) u32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_imm_sel(in_imm_sel), .in_pc(pc32),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_target(out_target32),
        .out_sel(out_sel32), .out_illegal(out_illegal32)
    );

    imm_gen_pipe #(.XLEN(64)) u64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_imm_sel(in_imm_sel), .in_pc(pc64),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_target(out_target64),
        .out_sel(out_sel64), .out_illegal(out_illegal64)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [2:0] sel, input logic [63:0] pc);
        in_valid   = 1'b1;
        in_instr   = instr;
        in_imm_sel = sel;
        pc64       = pc;
        pc32       = pc[31:0];
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_imm_sel = '0; pc32 = '0; pc64 = '0;
        step(); step();
        check("rst_out_valid", 64'(out_valid32), 64'd0);
        check("rst_imm", 64'(out_imm32), 64'd0);
        check("rst_target", 64'(out_target32), 64'd0);
        check("rst_sel_ill", {61'd0, out_sel32}, 64'd0);
        check("rst_in_ready", 64'(in_ready32), 64'd0);
        rst = 1'b0;
        check("post_rst_same_cycle_ready", 64'(in_ready32), 64'd0);
        step();
        check("post_rst_next_ready", 64'(in_ready32), 64'd1);
        check("post_rst_out_valid", 64'(out_valid32), 64'd0);

        // I-type, 1-cycle latency
        out_ready = 1'b1;
        drive(32'hFFF00093, 3'b000, 64'h0);
        step();
        check("i_valid", 64'(out_valid32), 64'd1);
        check("i_imm", 64'(out_imm32), 64'hFFFFFFFF);
        check("i_target", 64'(out_target32), 64'hFFFFFFFF);
        check("i_illegal", 64'(out_illegal32), 64'd0);

        drive(32'hFE000EE3, 3'b011, 64'h100);
        step();
        check("b_imm", 64'(out_imm32), 64'hFFFFFFFC);
        check("b_target", 64'(out_target32), 64'h000000FC);
        check("b_sel", 64'(out_sel32), 64'd3);

        drive(32'h0080006F, 3'b100, 64'hFFFFFFFC);
        step();
        check("j_imm", 64'(out_imm32), 64'h8);
        check("j_target_wrap", 64'(out_target32), 64'h4);

        drive(32'h00112423, 3'b010, 64'h1000);
        step();
        check("s_imm", 64'(out_imm32), 64'h8);
        check("s_target", 64'(out_target32), 64'h1008);

        // 64-bit instance formats
        drive(32'h800000B7, 3'b001, 64'h1000);
        step();
        check("u64_imm", out_imm64, 64'hFFFFFFFF80000000);
        check("u64_target", out_target64, 64'hFFFFFFFF80001000);
        check("u32_imm", 64'(out_imm32), 64'h80000000);

        drive(32'h000FD073, 3'b101, 64'h0);
        step();
        check("z64_imm", out_imm64, 64'h1F);
        check("z32_imm", 64'(out_imm32), 64'h1F);
        check("z64_illegal", 64'(out_illegal64), 64'd0);

        drive(32'hFFFFFFFF, 3'b111, 64'h40);
        step();
        check("ill64_imm", out_imm64, 64'd0);
        check("ill64_flag", 64'(out_illegal64), 64'd1);
        check("ill64_target", out_target64, 64'h40);
        check("ill64_sel", 64'(out_sel64), 64'd7);

        in_valid = 1'b0;
        step();
        check("drain_empty", 64'(out_valid32), 64'd0);

        // Backpressure: A, B fill the buffer, C is held off
        out_ready = 1'b0;
        drive(32'h00500093, 3'b000, 64'h0);
        step();
        drive(32'h00600093, 3'b000, 64'h0);
        step();
        check("bp_full_ready", 64'(in_ready32), 64'd0);
        check("bp_a_held", 64'(out_imm32), 64'd5);
        drive(32'h00700093, 3'b000, 64'h0);
        step();
        check("bp_c_blocked", 64'(in_ready32), 64'd0);
        check("bp_a_stable", 64'(out_imm32), 64'd5);
        check("bp_a_valid", 64'(out_valid32), 64'd1);
        out_ready = 1'b1;
        step();
        check("bp_b_out", 64'(out_imm32), 64'd6);
        check("bp_b_valid", 64'(out_valid32), 64'd1);
        check("bp_ready_back", 64'(in_ready32), 64'd1);
        step();
        check("bp_c_out", 64'(out_imm32), 64'd7);
        check("bp_c_valid", 64'(out_valid32), 64'd1);
        in_valid = 1'b0;
        step();
        check("bp_done", 64'(out_valid32), 64'd0);

        // Flush while FULL, with a new entry offered
        out_ready = 1'b0;
        drive(32'h00100093, 3'b000, 64'h0);
        step();
        drive(32'h00200093, 3'b000, 64'h0);
        step();
        check("fl_full", 64'(in_ready32), 64'd0);
        flush = 1'b1;
        drive(32'h00300093, 3'b000, 64'h0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", 64'(out_valid32), 64'd0);
        check("fl_in_ready", 64'(in_ready32), 64'd1);
        out_ready = 1'b1;
        step();
        check("fl_not_captured", 64'(out_valid32), 64'd0);

        // Reset mid-stream
        drive(32'h00900093, 3'b000, 64'h20);
        step();
        check("mid_imm", 64'(out_imm32), 64'd9);
        check("mid_target", 64'(out_target32), 64'h29);
        rst = 1'b1;
        out_ready = 1'b0;
        step();
        check("mid_rst_valid", 64'(out_valid32), 64'd0);
        check("mid_rst_imm", 64'(out_imm32), 64'd0);
        check("mid_rst_target", 64'(out_target32), 64'd0);
        check("mid_rst_ready", 64'(in_ready32), 64'd0);
        check("mid_rst_imm64", out_imm64, 64'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
